// File: rtl/eq4_bist_if.sv
// eq4_bist_if: bundles the sweep control and comparator-facing signals of the
// eq4 BIST sequencer.
//   start      - begin a sweep (sampled in IDLE and DONE)
//   a_out/b_out- operand pair driven to the comparator under test
//   y_in       - comparator equality result
//   busy/done  - sweep in progress / sweep complete
//   pass       - no mismatches seen (valid while done=1)
//   err_count  - saturating mismatch count
//   fail_valid - a mismatch was captured; fail_a/fail_b hold its operands
// master: the sequencer. slave: the environment around it.
interface eq4_bist_if #(
    parameter int WIDTH = 4,
    parameter int ERRW  = 8
);
    logic             start;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic             y_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERRW-1:0]  err_count;
    logic             fail_valid;
    logic [WIDTH-1:0] fail_a;
    logic [WIDTH-1:0] fail_b;

    modport master (
        input  start, y_in,
        output a_out, b_out, busy, done, pass, err_count,
               fail_valid, fail_a, fail_b
    );

    modport slave (
        output start, y_in,
        input  a_out, b_out, busy, done, pass, err_count,
               fail_valid, fail_a, fail_b
    );
endinterface

// File: rtl/eq4_bist.sv
// eq4_bist: built-in self-test sequencer for an equality comparator.
// On start it walks every (a, b) operand pair ({a,b} counting up, b in the
// LSBs), holds each pair SETTLE cycles, then samples y_in and checks it
// against a==b. Reports pass, a saturating mismatch count and the first
// failing pair.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset; clears state and all outputs
//   bus   - eq4_bist_if master modport (start, y_in in; operands/status out)
module eq4_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2,
    parameter int ERRW   = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    eq4_bist_if.master  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CW-1:0]    r_cnt;
    logic [ERRW-1:0]  r_err;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             r_fail_valid;
    logic [WIDTH-1:0] r_fail_a;
    logic [WIDTH-1:0] r_fail_b;

    logic             w_mis;
    logic             w_last;
    logic [PW-1:0]    w_pair_next;

    // A mismatch is the comparator disagreeing with the locally computed a==b.
    assign w_mis       = bus.y_in != (r_a == r_b);
    assign w_last      = ({r_a, r_b} == {PW{1'b1}});
    assign w_pair_next = {r_a, r_b} + PW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_b          <= '0;
            r_cnt        <= '0;
            r_err        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail_valid <= 1'b0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_state      <= S_RUN;
                        r_a          <= '0;
                        r_b          <= '0;
                        r_cnt        <= CW'(SETTLE - 1);
                        r_err        <= '0;
                        r_fail_valid <= 1'b0;
                        r_fail_a     <= '0;
                        r_fail_b     <= '0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                    end
                end

                S_RUN: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        // Sample edge: count, capture first failure, advance.
                        if (w_mis) begin
                            if (r_err != {ERRW{1'b1}}) begin
                                r_err <= r_err + ERRW'(1);
                            end
                            if (!r_fail_valid) begin
                                r_fail_valid <= 1'b1;
                                r_fail_a     <= r_a;
                                r_fail_b     <= r_b;
                            end
                        end
                        if (w_last) begin
                            // Final sample is folded into pass here so pass is
                            // already correct when done rises.
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (r_err == '0) && !w_mis;
                        end else begin
                            {r_a, r_b} <= w_pair_next;
                            r_cnt      <= CW'(SETTLE - 1);
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.a_out      = r_a;
    assign bus.b_out      = r_b;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pass       = r_pass;
    assign bus.err_count  = r_err;
    assign bus.fail_valid = r_fail_valid;
    assign bus.fail_a     = r_fail_a;
    assign bus.fail_b     = r_fail_b;
endmodule
